// File: rtl/counter_pkg.sv
// Shared types and helpers for the parameterised up/down counter.
// COUNTER_SATURATE_EN (see param_updown_counter) selects saturating limits.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } count_mode_e;

  localparam int MIN_PRESC_W = 1;

  // Prescaler counter width; a single bit is kept even when PRESCALE is 1 or 2.
  function automatic int presc_width(input int prescale);
    return ($clog2(prescale) < MIN_PRESC_W) ? MIN_PRESC_W : $clog2(prescale);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: step strobes once every PRESCALE enabled cycles,
// tick is that strobe delayed by one register.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic step,
  output logic tick
);

  localparam int            PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign step = en && (cnt == LAST);

  // Frozen entirely while en is low; clear only matters on enabled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= step;
      if (en) begin
        if (clear || step) cnt <= '0;
        else               cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parameterised up/down/hold/load counter with prescaled step and a registered
// terminal-count pulse. Define COUNTER_SATURATE_EN to pin at the limits instead of wrapping.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             tick
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be 2..16");
  end
  if (MAX_COUNT < 1 || MAX_COUNT >= (1 << WIDTH)) begin : g_bad_max
    $error("param_updown_counter: MAX_COUNT must be 1..2**WIDTH-1");
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("param_updown_counter: PRESCALE must be 1..256");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  count_mode_e      mode_e;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;

  assign mode_e = count_mode_e'(mode);
  assign load   = en && (mode_e == MODE_LOAD);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (load),
    .step  (step),
    .tick  (tick)
  );

  // step already implies en, so a disabled cycle falls through to hold with tc low.
  always_comb begin
    count_n = count;
    tc_n    = 1'b0;
    if (load) begin
      count_n = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step) begin
      case (mode_e)
`ifdef COUNTER_SATURATE_EN
        MODE_UP: if (count != MAX_V) begin
          count_n = count + 1'b1;
          tc_n    = (count == MAX_V - 1'b1);
        end
        MODE_DOWN: if (count != '0) begin
          count_n = count - 1'b1;
          tc_n    = (count == WIDTH'(1));
        end
`else
        MODE_UP: begin
          count_n = (count == MAX_V) ? '0 : count + 1'b1;
          tc_n    = (count == MAX_V);
        end
        MODE_DOWN: begin
          count_n = (count == '0) ? MAX_V : count - 1'b1;
          tc_n    = (count == '0);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_n;
      tc    <= tc_n;
    end
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's fixed 4-bit free-running up counter. Adds:
- Configurable width and modulus.
- Up, down, hold and load modes.
- A clock-enable prescaler.
- A registered terminal-count pulse.

Sits behind the tile's dedicated I/O: ui_in drives mode, enable and load value; uo_out shows the count.

Parameters:
WIDTH, 4, counter width in bits (2..16)
MAX_COUNT, 15, highest count value; range 1..2**WIDTH-1; count sequence is 0..MAX_COUNT
PRESCALE, 1, count advances once every PRESCALE clk cycles while enabled; 1 = every cycle (1..256)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; low freezes count and prescaler
mode  input  2  00 hold, 01 up, 10 down, 11 load
load_val  input  WIDTH  value for load mode
count  output  WIDTH  current count, registered
tc  output  1  one-cycle pulse on wrap (up past MAX_COUNT or down past 0)
tick  output  1  one-cycle pulse, prescaler terminal, registered

Behaviour:
- Reset (async assert, sync-released by the system):
  - count=0, tc=0, tick=0, prescaler=0.
  - Reset mid-count clears everything within the same cycle; no pending tc survives.
- Prescaler:
  - Internal counter 0..PRESCALE-1, advances only when en=1.
  - Internal step strobe is asserted in the cycle the prescaler is at PRESCALE-1. The prescaler then returns to 0.
  - tick is that strobe registered (one cycle later).
  - PRESCALE=1: the step strobe is constantly 1 while en=1.
- Count update, on rising clk, in priority order:
  1. en=0: count, prescaler and tc hold; tc=0.
  2. mode=11 (load): count <= min(load_val, MAX_COUNT) in the same cycle, independent of the step strobe.
     - Prescaler cleared to 0.
     - tc=0.
  3. mode=01 (up) and step strobe:
     - count==MAX_COUNT -> count<=0, tc<=1.
     - else count<=count+1, tc<=0.
  4. mode=10 (down) and step strobe:
     - count==0 -> count<=MAX_COUNT, tc<=1.
     - else count<=count-1, tc<=0.
  5. mode=00, or no strobe: count holds, tc<=0.
     - mode=00 still advances the prescaler.
- Timing:
  - Latency: count reflects a step one cycle after the strobe cycle.
  - tc is asserted in the same cycle the wrapped value appears on count.
- Arithmetic:
  - Width WIDTH, unsigned.
  - Comparisons use MAX_COUNT cast to WIDTH bits; no overflow beyond WIDTH is possible.
- Mode change between strobes takes effect at the next strobe; no count glitch.
- An illegal parameter combination (MAX_COUNT >= 2**WIDTH, PRESCALE=0) is a simulation elaboration error.

Optional Feature:
COUNTER_SATURATE_EN
- Defined:
  - Up at MAX_COUNT holds MAX_COUNT.
  - Down at 0 holds 0.
  - tc is asserted for one cycle on the first strobe that hits the limit. tc stays low on further strobes while pinned.
- Undefined: wrap-around behaviour as above.
- Load and prescaler behave identically in both builds.

Decomposition:
- Package counter_pkg holds:
  - typedef enum logic[1:0] count_mode_e {MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD}.
  - Localparam helpers for prescaler width: $clog2(PRESCALE), minimum 1.
- One sub-module, tick_prescaler.
  - Parameter PRESCALE.
  - Ports: clk, reset, en, clear.
  - Outputs: step (combinational strobe) and tick (registered).
- Top module: mode decode, count register, tc register.

Test Plan:
- WIDTH=4, MAX=15, PRESCALE=1; reset, en=1, mode=01 for 17 cycles -> count 0,1,..,15,0,1; tc=1 only in the cycle count shows 0 after 15.
- MAX=9; mode=10 from reset for 3 cycles -> count 9,8,7; tc=1 in the cycle count first shows 9.
- PRESCALE=4, mode=01, en=1 for 12 cycles -> count increments every 4th cycle (0,..,3 over 12 cycles); tick pulses every 4 cycles; en=0 for 5 cycles -> count and tick frozen.
- Load:
  - mode=11, load_val=12, MAX=9 -> count=9 next cycle.
  - load_val=5 -> count=5; then mode=01 -> 6 after the first strobe, prescaler restarted from 0.
- Reset asserted mid-count at count=7, tc pending from wrap -> count=0, tc=0 immediately; after release, counting resumes from 0 with the prescaler at 0.
- With COUNTER_SATURATE_EN, MAX=15, mode=01 for 20 cycles -> count sticks at 15; tc=1 exactly once, on the strobe count reaches 15; mode=10 from 0 -> stays 0.
